// File: rtl/execute_div_arbiter_pkg.sv
// rtl/execute_div_arbiter_pkg.sv - shared state encodings, port indices and arbitration helper
package execute_div_arbiter_pkg;

    localparam logic DIV_PORT_EXEC = 1'b0;
    localparam logic DIV_PORT_SEQ  = 1'b1;

    typedef enum logic [1:0] {
        ST_ARB_IDLE  = 2'd0,
        ST_ARB_RUN   = 2'd1,
        ST_ARB_DONE  = 2'd2,
        ST_ARB_DRAIN = 2'd3
    } arb_state_t;

    // On a tie the port that did not complete last wins, unless fixed priority is set.
    function automatic logic pick_winner(input logic r0, input logic r1,
                                         input logic last, input logic fixed);
        if (r0 && (fixed || !r1 || last))
            return DIV_PORT_EXEC;
        return DIV_PORT_SEQ;
    endfunction

endpackage

// File: rtl/execute_div_arb_cache.sv
// rtl/execute_div_arb_cache.sv - one-entry divide result cache with operand hit compare
module execute_div_arb_cache #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_a,
    input  logic [WIDTH-1:0] wr_b,
    input  logic             wr_uns,
    input  logic [WIDTH-1:0] wr_res,
    input  logic             wr_ov,
    input  logic [WIDTH-1:0] lk_a,
    input  logic [WIDTH-1:0] lk_b,
    input  logic             lk_uns,
    output logic             hit,
    output logic [WIDTH-1:0] hit_res,
    output logic             hit_ov
);

    logic             valid;
    logic [WIDTH-1:0] ent_a;
    logic [WIDTH-1:0] ent_b;
    logic             ent_uns;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            valid <= 1'b0;
        else if (wr_en)
            valid <= 1'b1;
    end

    // Payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent_a   <= wr_a;
            ent_b   <= wr_b;
            ent_uns <= wr_uns;
            hit_res <= wr_res;
            hit_ov  <= wr_ov;
        end
    end

    assign hit = valid && (ent_a == lk_a) && (ent_b == lk_b) && (ent_uns == lk_uns);

endmodule

// File: rtl/execute_div_arbiter.sv
// rtl/execute_div_arbiter.sv - two-port arbiter for a shared divider; EXECUTE_DIV_ARB_CACHE_EN adds a result cache
module execute_div_arbiter
    import execute_div_arbiter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             uns0,
    input  logic             uns1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res,
    output logic             res_ov,
    output logic             div_enable,
    output logic             div_unsigned,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_out,
    input  logic             div_ov
);

    arb_state_t       state;
    logic             owner;
    logic             last_grant;
    logic             win;
    logic             req_owner;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             uns_sel;

    assign win       = pick_winner(req0, req1, last_grant, FIXED_PRIO);
    assign a_sel     = (win == DIV_PORT_SEQ) ? a1 : a0;
    assign b_sel     = (win == DIV_PORT_SEQ) ? b1 : b0;
    assign uns_sel   = (win == DIV_PORT_SEQ) ? uns1 : uns0;
    assign req_owner = (owner == DIV_PORT_SEQ) ? req1 : req0;

`ifdef EXECUTE_DIV_ARB_CACHE_EN
    logic             hit;
    logic [WIDTH-1:0] hit_res;
    logic             hit_ov;

    execute_div_arb_cache #(.WIDTH(WIDTH)) u_cache (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   ((state == ST_ARB_RUN) && req_owner && div_done),
        .wr_a    (div_a),
        .wr_b    (div_b),
        .wr_uns  (div_unsigned),
        .wr_res  (div_out),
        .wr_ov   (div_ov),
        .lk_a    (a_sel),
        .lk_b    (b_sel),
        .lk_uns  (uns_sel),
        .hit     (hit),
        .hit_res (hit_res),
        .hit_ov  (hit_ov)
    );
`endif

    // Reset lands in DRAIN so a divider that kept running through reset is idle before any grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_ARB_DRAIN;
            owner        <= DIV_PORT_EXEC;
            last_grant   <= DIV_PORT_SEQ;
            div_enable   <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            res          <= '0;
            res_ov       <= 1'b0;
            div_a        <= '0;
            div_b        <= '0;
            div_unsigned <= 1'b0;
        end else begin
            case (state)
                ST_ARB_IDLE: begin
                    if (req0 || req1) begin
                        owner        <= win;
                        div_a        <= a_sel;
                        div_b        <= b_sel;
                        div_unsigned <= uns_sel;
`ifdef EXECUTE_DIV_ARB_CACHE_EN
                        if (hit) begin
                            res    <= hit_res;
                            res_ov <= hit_ov;
                            done0  <= (win == DIV_PORT_EXEC);
                            done1  <= (win == DIV_PORT_SEQ);
                            state  <= ST_ARB_DONE;
                        end else begin
                            div_enable <= 1'b1;
                            state      <= ST_ARB_RUN;
                        end
`else
                        div_enable <= 1'b1;
                        state      <= ST_ARB_RUN;
`endif
                    end
                end
                ST_ARB_RUN: begin
                    // A withdrawn request beats a coincident completion.
                    if (!req_owner) begin
                        div_enable <= 1'b0;
                        state      <= ST_ARB_DRAIN;
                    end else if (div_done) begin
                        res    <= div_out;
                        res_ov <= div_ov;
                        done0  <= (owner == DIV_PORT_EXEC);
                        done1  <= (owner == DIV_PORT_SEQ);
                        state  <= ST_ARB_DONE;
                    end
                end
                ST_ARB_DONE: begin
                    if (!req_owner) begin
                        done0      <= 1'b0;
                        done1      <= 1'b0;
                        div_enable <= 1'b0;
                        last_grant <= owner;
                        state      <= ST_ARB_DRAIN;
                    end
                end
                ST_ARB_DRAIN: begin
                    if (!div_done)
                        state <= ST_ARB_IDLE;
                end
                default: state <= ST_ARB_DRAIN;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_div_arbiter.sv
// tb/tb_execute_div_arbiter.sv - randomized self-checking bench with a behavioural divider and arbitration model
module tb_execute_div_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        uns0 = 1'b0, uns1 = 1'b0;
    logic        done0, done1;
    logic [31:0] res;
    logic        res_ov;
    logic        div_enable, div_unsigned;
    logic [31:0] div_a, div_b;
    logic        div_done = 1'b0;
    logic [31:0] div_out = '0;
    logic        div_ov = 1'b0;

    int checks = 0;
    int fails  = 0;
    int lat = 2;
    int drain_lat = 1;
    int busy_cnt = 0;
    int drop_cnt = 0;
    logic ref_last = 1'b1;

    execute_div_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req0         (req0),
        .req1         (req1),
        .a0           (a0),
        .b0           (b0),
        .a1           (a1),
        .b1           (b1),
        .uns0         (uns0),
        .uns1         (uns1),
        .done0        (done0),
        .done1        (done1),
        .res          (res),
        .res_ov       (res_ov),
        .div_enable   (div_enable),
        .div_unsigned (div_unsigned),
        .div_a        (div_a),
        .div_b        (div_b),
        .div_done     (div_done),
        .div_out      (div_out),
        .div_ov       (div_ov)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Divider semantics: {ov, quotient}; divide by zero returns the dividend with ov.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic u);
        logic [31:0] q;
        if (b == 32'd0) return {1'b1, a};
        if (!u && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        if (u) q = a / b;
        else   q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    // Stand-in divider: not tied to reset_n, so it keeps its state across an arbiter reset.
    always @(posedge clk) begin
        if (div_enable) begin
            drop_cnt <= 0;
            if (!div_done) begin
                if (busy_cnt + 1 >= lat) begin
                    div_done          <= 1'b1;
                    {div_ov, div_out} <= ref_div(div_a, div_b, div_unsigned);
                    busy_cnt          <= 0;
                end else begin
                    busy_cnt <= busy_cnt + 1;
                end
            end
        end else begin
            busy_cnt <= 0;
            if (div_done) begin
                if (drop_cnt >= drain_lat) begin
                    div_done <= 1'b0;
                    drop_cnt <= 0;
                end else begin
                    drop_cnt <= drop_cnt + 1;
                end
            end
        end
    end

    function automatic logic get_done(input int p);
        return (p != 0) ? done1 : done0;
    endfunction

    task automatic set_req(input int p, input logic v);
        if (p != 0) req1 = v; else req0 = v;
    endtask

    task automatic set_ops(input int p, input logic [31:0] a, input logic [31:0] b, input logic u);
        if (p != 0) begin a1 = a; b1 = b; uns1 = u; end
        else begin a0 = a; b0 = b; uns0 = u; end
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (div_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 100) begin
            fails++;
            $display("FAIL %s drain timeout div_done=%b required 0", name, div_done);
        end
        @(negedge clk);
    endtask

    // Waits for the port's done, checks latency/result/hold, then withdraws the request.
    task automatic serve(input string name, input int port, input logic [31:0] eq, input logic eov);
        int cyc = 0;
        int cnt_dd = 0;
        bit other_bad = 0;
        while (get_done(port) !== 1'b1 && cyc < 200) begin
            if (div_enable && div_done) cnt_dd++;
            if (get_done(1 - port) !== 1'b0) other_bad = 1;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            fails++;
            $display("FAIL %s done%0d timeout got 0 required 1", name, port);
            set_req(port, 1'b0);
        end else begin
            checks++;
            if (cnt_dd !== 1) begin
                fails++;
                $display("FAIL %s done latency got %0d cycles after div_done required 1", name, cnt_dd);
            end
            checks++;
            if (res !== eq || res_ov !== eov) begin
                fails++;
                $display("FAIL %s result got %h/%b required %h/%b", name, res, res_ov, eq, eov);
            end
            checks++;
            if (other_bad || get_done(1 - port) !== 1'b0) begin
                fails++;
                $display("FAIL %s non-owner done got 1 required 0", name);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            checks++;
            if (get_done(port) !== 1'b1 || res !== eq || div_enable !== 1'b1) begin
                fails++;
                $display("FAIL %s hold got done=%b res=%h en=%b required 1/%h/1",
                         name, get_done(port), res, div_enable, eq);
            end
            set_req(port, 1'b0);
            @(negedge clk);
            checks++;
            if (get_done(port) !== 1'b0 || div_enable !== 1'b0 || res !== eq || res_ov !== eov) begin
                fails++;
                $display("FAIL %s release got done=%b en=%b res=%h required 0/0/%h",
                         name, get_done(port), div_enable, res, eq);
            end
            ref_last = (port != 0);
        end
    endtask

    task automatic test_single(input string name, input int port, input logic [31:0] a,
                               input logic [31:0] b, input logic u,
                               input logic [31:0] eq, input logic eov);
        set_ops(port, a, b, u);
        set_req(port, 1'b1);
        @(negedge clk);
        checks++;
        if (div_enable !== 1'b1 || div_a !== a || div_b !== b || div_unsigned !== u) begin
            fails++;
            $display("FAIL %s grant got en=%b a=%h b=%h u=%b required 1/%h/%h/%b",
                     name, div_enable, div_a, div_b, div_unsigned, a, b, u);
        end
        serve(name, port, eq, eov);
        wait_idle(name);
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if ({done0, done1, res, res_ov, div_enable, div_a, div_b, div_unsigned} !== '0) begin
            fails++;
            $display("FAIL %s got d0=%b d1=%b res=%h ov=%b en=%b a=%h b=%h u=%b required all 0",
                     name, done0, done1, res, res_ov, div_enable, div_a, div_b, div_unsigned);
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_values");
        repeat (2) @(negedge clk);
        check_reset_vals("reset_held");
        reset_n = 1'b1;
        ref_last = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_release_idle");
    endtask

    task automatic test_tie();
        int first;
        logic [31:0] e0, e1;
        set_ops(0, 32'hFFFF_FFF0, 32'd4, 1'b1);
        set_ops(1, 32'hFFFF_FFF7, 32'd2, 1'b0);
        e0 = 32'h3FFF_FFFC;
        e1 = 32'hFFFF_FFFC;
        req0 = 1'b1;
        req1 = 1'b1;
        first = ref_last ? 0 : 1;
        @(negedge clk);
        checks++;
        if (div_enable !== 1'b1 || div_a !== (first != 0 ? a1 : a0)) begin
            fails++;
            $display("FAIL tie_first_grant got en=%b a=%h required port %0d", div_enable, div_a, first);
        end
        serve("tie_first", first, first != 0 ? e1 : e0, 1'b0);
        // Re-raise the served port at once: the round-robin must hand the next tie to the other.
        if (first == 0) begin
            set_ops(0, 32'd1000, 32'd10, 1'b0);
            e0 = 32'd100;
        end else begin
            set_ops(1, 32'd1000, 32'd10, 1'b0);
            e1 = 32'd100;
        end
        set_req(first, 1'b1);
        serve("tie_second", 1 - first, first != 0 ? e0 : e1, 1'b0);
        serve("tie_third", first, first != 0 ? e1 : e0, 1'b0);
        wait_idle("tie");
    endtask

    task automatic test_basic();
        test_single("basic_100_7", 0, 32'd100, 32'd7, 1'b0, 32'd14, 1'b0);
    endtask

    task automatic test_overflow();
        test_single("div_by_zero", 1, 32'h8000_0000, 32'd0, 1'b0, 32'h8000_0000, 1'b1);
        test_single("min_by_neg1", 0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1);
        test_single("unsigned_min_neg1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0);
    endtask

    // After div_done is first seen low, IDLE follows one edge later and the grant one edge after that.
    task automatic check_drain_then_grant(input string name, input logic [31:0] a);
        int cyc = 0;
        bit bad = 0;
        while (div_done && cyc < 100) begin
            if (div_enable !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) bad = 1;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bad || cyc >= 100) begin
            fails++;
            $display("FAIL %s drain hold got early grant/done or timeout cyc=%0d required none", name, cyc);
        end
        @(negedge clk);
        checks++;
        if (div_enable !== 1'b0) begin
            fails++;
            $display("FAIL %s drain exit got en=%b required 0", name, div_enable);
        end
        @(negedge clk);
        checks++;
        if (div_enable !== 1'b1 || div_a !== a) begin
            fails++;
            $display("FAIL %s regrant got en=%b a=%h required 1/%h", name, div_enable, div_a, a);
        end
    endtask

    task automatic test_cancel();
        int cyc = 0;
        bit bad = 0;
        lat = 6;
        drain_lat = 1;
        set_ops(0, 32'd77, 32'd3, 1'b0);
        req0 = 1'b1;
        repeat (3) @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (div_enable !== 1'b0 || done0 !== 1'b0) begin
            fails++;
            $display("FAIL cancel_mid got en=%b done0=%b required 0/0", div_enable, done0);
        end
        repeat (8) begin
            if (done0 !== 1'b0) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL cancel_mid_no_done got 1 required 0");
        end
        test_single("after_cancel", 1, 32'd81, 32'd9, 1'b1, 32'd9, 1'b0);

        lat = 2;
        drain_lat = 3;
        set_ops(0, 32'd50, 32'd5, 1'b0);
        req0 = 1'b1;
        while (!div_done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (div_enable !== 1'b0 || done0 !== 1'b0) begin
            fails++;
            $display("FAIL cancel_at_done got en=%b done0=%b required 0/0", div_enable, done0);
        end
        set_ops(1, 32'd200, 32'd8, 1'b1);
        req1 = 1'b1;
        check_drain_then_grant("cancel_at_done", 32'd200);
        serve("cancel_next", 1, 32'd25, 1'b0);
        wait_idle("cancel_next");
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        lat = 2;
        drain_lat = 3;
        set_ops(1, 32'h1234, 32'h10, 1'b1);
        req1 = 1'b1;
        while (!div_done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        reset_n = 1'b0;
        req1 = 1'b0;
        #1;
        check_reset_vals("reset_mid_run");
        @(negedge clk);
        reset_n = 1'b1;
        ref_last = 1'b1;
        set_ops(1, 32'd300, 32'd7, 1'b0);
        req1 = 1'b1;
        check_drain_then_grant("reset_mid", 32'd300);
        serve("reset_mid_next", 1, 32'd42, 1'b0);
        wait_idle("reset_mid_next");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int mode;
            int first;
            logic [31:0] ra [2];
            logic [31:0] rb [2];
            logic        ru [2];
            logic [32:0] e  [2];
            lat = $urandom_range(1, 4);
            drain_lat = $urandom_range(0, 2);
            for (int p = 0; p < 2; p++) begin
                ra[p] = $urandom;
                case ($urandom_range(0, 7))
                    0:       rb[p] = 32'd0;
                    1, 2:    rb[p] = $urandom_range(1, 50);
                    3:       rb[p] = -$urandom_range(1, 50);
                    default: rb[p] = $urandom;
                endcase
                ru[p] = $urandom_range(0, 1);
                e[p]  = ref_div(ra[p], rb[p], ru[p]);
                set_ops(p, ra[p], rb[p], ru[p]);
            end
            mode = $urandom_range(0, 2);
            if (mode < 2) begin
                test_single("rand_single", mode, ra[mode], rb[mode], ru[mode], e[mode][31:0], e[mode][32]);
            end else begin
                first = ref_last ? 0 : 1;
                req0 = 1'b1;
                req1 = 1'b1;
                serve("rand_tie_first", first, e[first][31:0], e[first][32]);
                serve("rand_tie_second", 1 - first, e[1 - first][31:0], e[1 - first][32]);
                wait_idle("rand_tie");
            end
        end
    endtask

`ifdef EXECUTE_DIV_ARB_CACHE_EN
    task automatic test_cache();
        lat = 3;
        drain_lat = 1;
        test_single("cache_fill", 0, 32'd100, 32'd7, 1'b0, 32'd14, 1'b0);
        req0 = 1'b1;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || div_enable !== 1'b0 || res !== 32'd14 || res_ov !== 1'b0) begin
            fails++;
            $display("FAIL cache_hit got done0=%b en=%b res=%h required 1/0/0000000e", done0, div_enable, res);
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || div_enable !== 1'b0) begin
            fails++;
            $display("FAIL cache_hit_release got done0=%b en=%b required 0/0", done0, div_enable);
        end
        wait_idle("cache_hit");
        test_single("cache_miss_uns", 0, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_tie();
        test_basic();
        test_overflow();
        test_cancel();
        test_reset_mid();
        test_random();
`ifdef EXECUTE_DIV_ARB_CACHE_EN
        test_cache();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
